// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on mem_ready_i and traps on illegal encodings or stuck memory accesses.
module multicycle_controller #(
  parameter int ALU_CTRL_W = 4,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [31:0]           instr_i,
  input  logic                  zero_i,
  input  logic                  mem_ready_i,
  output logic                  pc_write_o,
  output logic                  ir_write_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic                  iord_o,
  output logic                  reg_write_o,
  output logic [1:0]            result_src_o,
  output logic [1:0]            alu_src_a_o,
  output logic [1:0]            alu_src_b_o,
  output logic [ALU_CTRL_W-1:0] alu_control_o,
  output logic                  pc_src_o,
  output logic [3:0]            state_o,
  output logic                  trap_o,
  output logic [1:0]            trap_cause_o
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_EXEC_I    = 4'd7,
    S_ALU_WB    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_LUI       = 4'd11,
    S_TRAP      = 4'd15
  } state_t;

  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(4'b0010);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(4'b0110);
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(4'b0000);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(4'b0001);

  localparam logic [1:0] A_PC   = 2'd0;
  localparam logic [1:0] A_RS1  = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;
  localparam logic [1:0] A_OLD  = 2'd3;
  localparam logic [1:0] B_RS2  = 2'd0;
  localparam logic [1:0] B_FOUR = 2'd1;
  localparam logic [1:0] B_IMM  = 2'd2;

  localparam logic [1:0] RES_ALU = 2'd0;
  localparam logic [1:0] RES_MEM = 2'd1;
  localparam logic [1:0] RES_PC  = 2'd2;

  localparam logic [1:0] CAUSE_ILL  = 2'd1;
  localparam logic [1:0] CAUSE_TIME = 2'd2;

  state_t     state;
  state_t     state_n;
  logic [7:0] wait_cnt;
  logic [1:0] cause;
  logic [1:0] cause_n;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_instr;

  assign opcode       = instr_i[6:0];
  assign funct3       = instr_i[14:12];
  assign funct7       = instr_i[31:25];
  assign unused_instr = ^{instr_i[24:15], instr_i[11:7]};

  logic                  r_legal;
  logic                  i_legal;
  logic                  b_legal;
  logic                  b_take;
  logic [ALU_CTRL_W-1:0] r_alu;
  logic [ALU_CTRL_W-1:0] i_alu;

  always_comb begin
    r_legal = 1'b1;
    r_alu   = ALU_ADD;
    unique case (1'b1)
      (funct7 == 7'h00 && funct3 == 3'b000): r_alu = ALU_ADD;
      (funct7 == 7'h00 && funct3 == 3'b111): r_alu = ALU_AND;
      (funct7 == 7'h00 && funct3 == 3'b110): r_alu = ALU_OR;
      (funct7 == 7'h20 && funct3 == 3'b000): r_alu = ALU_SUB;
      default:                               r_legal = 1'b0;
    endcase
  end

  always_comb begin
    i_legal = 1'b1;
    i_alu   = ALU_ADD;
    unique case (funct3)
      3'b000:  i_alu = ALU_ADD;
      3'b111:  i_alu = ALU_AND;
      3'b110:  i_alu = ALU_OR;
      default: i_legal = 1'b0;
    endcase
  end

  always_comb begin
    b_legal = 1'b1;
    b_take  = 1'b0;
    unique case (funct3)
      3'b000:  b_take = zero_i;
      3'b001:  b_take = ~zero_i;
      default: b_legal = 1'b0;
    endcase
  end

  logic is_wait;
  logic expired;

  assign is_wait = (state == S_FETCH) || (state == S_MEM_READ)
                || (state == S_MEM_WRITE);
  assign expired = (wait_cnt == WAIT_MAX);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_FETCH;
      wait_cnt <= 8'd0;
      cause    <= 2'd0;
    end else begin
      state <= state_n;
      // any state change re-arms the counter for the next wait state
      if (state_n != state)
        wait_cnt <= 8'd0;
      else if (is_wait && !mem_ready_i)
        wait_cnt <= wait_cnt + 8'd1;
      if (state_n == S_TRAP && state != S_TRAP)
        cause <= cause_n;
    end
  end

  always_comb begin
    state_n = state;
    cause_n = CAUSE_ILL;
    unique case (state)
      S_FETCH: begin
        if (mem_ready_i) state_n = S_DECODE;
        else if (expired) begin
          state_n = S_TRAP;
          cause_n = CAUSE_TIME;
        end
      end
      S_DECODE: begin
        unique case (opcode)
          7'h03, 7'h23: state_n = S_MEM_ADDR;
          7'h33:        state_n = S_EXEC_R;
          7'h13:        state_n = S_EXEC_I;
          7'h63:        state_n = S_BRANCH;
          7'h6F:        state_n = S_JAL;
          7'h37:        state_n = S_LUI;
          default:      state_n = S_TRAP;
        endcase
      end
      S_MEM_ADDR:
        state_n = (opcode == 7'h03) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ: begin
        if (mem_ready_i) state_n = S_MEM_WB;
        else if (expired) begin
          state_n = S_TRAP;
          cause_n = CAUSE_TIME;
        end
      end
      S_MEM_WB: state_n = S_FETCH;
      S_MEM_WRITE: begin
        if (mem_ready_i) state_n = S_FETCH;
        else if (expired) begin
          state_n = S_TRAP;
          cause_n = CAUSE_TIME;
        end
      end
      S_EXEC_R: state_n = r_legal ? S_ALU_WB : S_TRAP;
      S_EXEC_I: state_n = i_legal ? S_ALU_WB : S_TRAP;
      S_ALU_WB: state_n = S_FETCH;
      S_BRANCH: state_n = b_legal ? S_FETCH : S_TRAP;
      S_JAL:    state_n = S_FETCH;
      S_LUI:    state_n = S_ALU_WB;
      S_TRAP:   state_n = S_TRAP;
      default:  state_n = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write_o    = 1'b0;
    ir_write_o    = 1'b0;
    mem_read_o    = 1'b0;
    mem_write_o   = 1'b0;
    iord_o        = 1'b0;
    reg_write_o   = 1'b0;
    result_src_o  = RES_ALU;
    alu_src_a_o   = A_PC;
    alu_src_b_o   = B_RS2;
    alu_control_o = ALU_ADD;
    pc_src_o      = 1'b0;
    trap_o        = 1'b0;
    unique case (state)
      S_FETCH: begin
        mem_read_o  = 1'b1;
        alu_src_b_o = B_FOUR;
        ir_write_o  = mem_ready_i;
        pc_write_o  = mem_ready_i;
      end
      S_DECODE: begin
        alu_src_a_o = A_OLD;
        alu_src_b_o = B_IMM;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = A_RS1;
        alu_src_b_o = B_IMM;
      end
      S_MEM_READ: begin
        mem_read_o = 1'b1;
        iord_o     = 1'b1;
      end
      S_MEM_WB: begin
        reg_write_o  = 1'b1;
        result_src_o = RES_MEM;
      end
      S_MEM_WRITE: begin
        mem_write_o = 1'b1;
        iord_o      = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a_o   = A_RS1;
        alu_control_o = r_alu;
      end
      S_EXEC_I: begin
        alu_src_a_o   = A_RS1;
        alu_src_b_o   = B_IMM;
        alu_control_o = i_alu;
      end
      S_ALU_WB: reg_write_o = 1'b1;
      S_BRANCH: begin
        alu_src_a_o   = A_RS1;
        alu_control_o = ALU_SUB;
        pc_src_o      = 1'b1;
        pc_write_o    = b_take;
      end
      S_JAL: begin
        pc_write_o   = 1'b1;
        pc_src_o     = 1'b1;
        reg_write_o  = 1'b1;
        result_src_o = RES_PC;
      end
      S_LUI: begin
        alu_src_a_o = A_ZERO;
        alu_src_b_o = B_IMM;
      end
      S_TRAP:  trap_o = 1'b1;
      default: ;
    endcase
  end

  assign state_o      = state;
  assign trap_cause_o = cause;

endmodule
